pixel_fb_writer: RTL
====================

PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 Parameter H_RES, default 320: active pixels per line.
REQ-002 Parameter V_RES, default 180: active lines per frame.
REQ-003 Parameter ADDR_W, default 17: framebuffer address width, which SHALL satisfy 2^ADDR_W >= H_RES*V_RES.
REQ-004 Port aclk  in  1: single clock; all logic on the rising edge.
REQ-005 Port areset  in  1: reset, asynchronous and active-high.
REQ-006 Ports pixel_axis_tdata  in  24, pixel_axis_tvalid  in  1, pixel_axis_tready  out  1: RGB888 pixel stream from the renderer.
REQ-007 Ports hcount_in  in  11 and vcount_in  in  10: pixel coordinates, qualified by pixel_axis_tvalid.
REQ-008 Ports fb_we  out  1, fb_addr  out  ADDR_W, fb_wdata  out  24: BRAM write port.
REQ-009 Port fb_bank  out  1: bank being written.
REQ-010 Port frame_done  out  1: one-cycle pulse at the end of a frame.
REQ-011 Port frame_count  out  16: completed frames, wrapping.
REQ-012 Port sync_err_count  out  8: resynchronisations, saturating at 255.

Function
REQ-013 A beat SHALL be accepted only on a cycle where pixel_axis_tvalid and pixel_axis_tready are both high.
REQ-014 States: IDLE, WRITE, DONE.
REQ-015 pixel_axis_tready SHALL be high in IDLE and WRITE, and low in DONE and during reset.
REQ-016 IDLE: beats are accepted and discarded; a beat at (0,0) is written and the block moves to WRITE.
REQ-017 WRITE: each accepted in-range beat SHALL write.
- fb_we is high exactly one cycle after acceptance.
- fb_addr = vcount_in*H_RES + hcount_in.
- fb_wdata = pixel_axis_tdata.
REQ-018 Beats with hcount_in >= H_RES or vcount_in >= V_RES SHALL be accepted, not written, and cause no state change.
REQ-019 An accepted beat at (H_RES-1, V_RES-1) in WRITE SHALL be written, and the next state SHALL be DONE.
REQ-020 DONE lasts exactly one cycle, then the block moves to WRITE.
- frame_done is high during that cycle.
- frame_count increments by 1, wrapping 65535 -> 0.
REQ-021 A beat at (0,0) accepted in WRITE, with the previous frame not completed, SHALL restart the frame.
- The beat is written.
- The state stays WRITE.
- sync_err_count increments (saturating).
- frame_done does not pulse.
REQ-022 Write latency is 1 cycle; sustained throughput is 1 beat/cycle except for the single DONE bubble per frame.
REQ-023 The address multiply SHALL be registered within the 1-cycle latency, with no combinational path from inputs to fb_addr.
REQ-024 Coordinates SHALL be sampled only with the accepted beat; hcount_in and vcount_in are ignored otherwise.

Reset
REQ-025 While areset is high, and asynchronously on assertion, the block SHALL hold:
- state = IDLE; pixel_axis_tready = 0.
- fb_we = 0; fb_addr = 0; fb_wdata = 0.
- fb_bank = 0; frame_done = 0.
- frame_count = 0; sync_err_count = 0.
REQ-026 Reset asserted mid-frame SHALL suppress any pending write; no fb_we pulse may follow reset assertion.
REQ-027 After reset deasserts, the block SHALL resynchronise at the next (0,0) beat.

Configuration
REQ-028 Macro FB_DOUBLE_BUFFER_EN.
- Defined: fb_bank toggles in the DONE cycle. fb_addr[ADDR_W-1] carries fb_bank, and the pixel address uses ADDR_W-1 bits.
- Undefined: fb_bank is constantly 0, and the pixel address uses all ADDR_W bits.

Structure
REQ-029 A shared package fb_pkg SHALL hold:
- the state enum;
- RGB888 pixel typedef;
- default H_RES and V_RES constants.
REQ-030 Coordinate-to-address conversion SHALL be a sub-module fb_addr_calc (registered, 1 cycle).
REQ-031 Everything else SHALL be flat in pixel_fb_writer.

Verification
REQ-032 Reset, then a full 320x180 raster at tvalid=1 -> 57600 fb_we pulses; the last has addr 57599; frame_done pulses once; frame_count=1.
REQ-033 Beats (5,3), (7,3), then (0,0) after reset -> the first two produce no fb_we; (0,0) writes addr 0 one cycle later.
REQ-034 Beat (400,10) in WRITE -> no fb_we, state unchanged; next beat (1,0) writes addr 1.
REQ-035 (0,0) arriving after 1000 pixels of a frame -> sync_err_count=1, no frame_done, addr 0 written.
REQ-036 With FB_DOUBLE_BUFFER_EN, two full frames -> fb_bank 0 -> 1 -> 0; second-frame pixel (0,0) writes addr 2^(ADDR_W-1).
REQ-037 areset asserted the cycle after an accepted beat -> fb_we stays 0; tready=0 while reset is high.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the pixel framebuffer writer.
package fb_pkg;

  localparam int unsigned H_RES_DEFAULT = 320;
  localparam int unsigned V_RES_DEFAULT = 180;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } fb_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Registered coordinate-to-linear-address conversion (one cycle latency).
module fb_addr_calc #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned PIX_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  output logic [PIX_W-1:0] addr
);

  logic [PIX_W-1:0] lin;

  // Only in-range coordinates are ever enabled, so truncation cannot lose bits.
  assign lin = PIX_W'(32'(vcount) * H_RES + 32'(hcount));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (en) begin
      addr <= lin;
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Writes an RGB888 pixel stream into a framebuffer BRAM, tracking frame sync.
// Optional FB_DOUBLE_BUFFER_EN: bank bit in fb_addr MSB, toggled once per frame.
module pixel_fb_writer
  import fb_pkg::*;
#(
  parameter int unsigned H_RES  = H_RES_DEFAULT,
  parameter int unsigned V_RES  = V_RES_DEFAULT,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [23:0]       pixel_axis_tdata,
  input  logic              pixel_axis_tvalid,
  output logic              pixel_axis_tready,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_wdata,
  output logic              fb_bank,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [7:0]        sync_err_count
);

`ifdef FB_DOUBLE_BUFFER_EN
  localparam int unsigned PIX_W = ADDR_W - 1;
`else
  localparam int unsigned PIX_W = ADDR_W;
`endif

  fb_state_e        state_q, state_d;
  logic             accept, in_range, at_origin, at_last;
  logic             write_req, sync_err_inc;
  logic             progress_q, progress_d;
  logic             we_q;
  rgb888_t          wdata_q;
  logic [15:0]      frame_count_q;
  logic [7:0]       sync_err_q;
  logic [PIX_W-1:0] pix_addr;

  assign pixel_axis_tready = ~areset & (state_q != StDone);
  assign accept    = pixel_axis_tvalid & pixel_axis_tready;
  assign in_range  = (32'(hcount_in) < H_RES) && (32'(vcount_in) < V_RES);
  assign at_origin = (hcount_in == '0) && (vcount_in == '0);
  assign at_last   = (32'(hcount_in) == H_RES - 1) && (32'(vcount_in) == V_RES - 1);

  // progress_q marks that the current frame already has pixels, so a new (0,0) is a resync.
  always_comb begin
    state_d      = state_q;
    progress_d   = progress_q;
    write_req    = 1'b0;
    sync_err_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && at_origin) begin
          write_req  = 1'b1;
          progress_d = 1'b1;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (accept && in_range) begin
          write_req  = 1'b1;
          progress_d = 1'b1;
          if (at_origin && progress_q) sync_err_inc = 1'b1;
          if (at_last) state_d = StDone;
        end
      end
      StDone: begin
        progress_d = 1'b0;
        state_d    = StWrite;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= StIdle;
      progress_q    <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      frame_count_q <= '0;
      sync_err_q    <= '0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      we_q       <= write_req;
      if (write_req) wdata_q <= rgb888_t'(pixel_axis_tdata);
      if (state_q == StDone) frame_count_q <= frame_count_q + 16'd1;
      if (sync_err_inc && (sync_err_q != 8'hFF)) sync_err_q <= sync_err_q + 8'd1;
    end
  end

  fb_addr_calc #(
    .H_RES(H_RES),
    .PIX_W(PIX_W)
  ) u_addr_calc (
    .clk   (aclk),
    .rst   (areset),
    .en    (write_req),
    .hcount(hcount_in),
    .vcount(vcount_in),
    .addr  (pix_addr)
  );

`ifdef FB_DOUBLE_BUFFER_EN
  logic bank_q;

  // The bank flips at the end of DONE, after the frame's last write has used the old bank.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bank_q <= 1'b0;
    end else if (state_q == StDone) begin
      bank_q <= ~bank_q;
    end
  end

  assign fb_bank = bank_q;
  assign fb_addr = {bank_q, pix_addr};
`else
  assign fb_bank = 1'b0;
  assign fb_addr = pix_addr;
`endif

  assign fb_we          = we_q;
  assign fb_wdata       = wdata_q;
  assign frame_done     = (state_q == StDone);
  assign frame_count    = frame_count_q;
  assign sync_err_count = sync_err_q;

endmodule
